// File: rtl/paddle_position_controller.sv
// Pong paddle position controller: registers the keypad levels, generates the move tick
// and runs an independent hold-to-accelerate FSM per paddle with clamped positions.
module paddle_position_controller #(
    parameter int Y_WIDTH     = 10,
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 80,
    parameter int TICK_DIV    = 4,
    parameter int SLOW_STEP   = 4,
    parameter int FAST_STEP   = 8,
    parameter int ACCEL_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up1,
    input  logic               down1,
    input  logic               up2,
    input  logic               down2,
    input  logic               recenter,
    input  logic               freeze,
    output logic [Y_WIDTH-1:0] paddle1_y,
    output logic [Y_WIDTH-1:0] paddle2_y,
    output logic               p1_fast,
    output logic               p2_fast,
    output logic               move_tick
);

    localparam int Y_MAX  = SCREEN_H - PADDLE_H;
    localparam int CENTER = Y_MAX / 2;
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);
    localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [Y_WIDTH:0]   Y_MAX_X  = (Y_WIDTH + 1)'(Y_MAX);
    localparam logic [Y_WIDTH-1:0] CENTER_Y = Y_WIDTH'(CENTER);
    localparam logic [Y_WIDTH-1:0] SLOW_Y   = Y_WIDTH'(SLOW_STEP);
    localparam logic [Y_WIDTH-1:0] FAST_Y   = Y_WIDTH'(FAST_STEP);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(ACCEL_TICKS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SLOW,
        FAST
    } state_t;

    logic [1:0]              up_q, down_q;
    logic                    recenter_q, freeze_q;
    logic [CNT_W-1:0]        tick_cnt_q, tick_cnt_d;
    logic [1:0][Y_WIDTH-1:0] y_q, y_d;
    logic [1:0][HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]              dir_up_q, dir_up_d;
    logic [1:0]              fast_q, fast_d;
    state_t                  state_q [2];
    state_t                  state_d [2];

    // Widened by one bit so neither direction can wrap before the clamp decision.
    function automatic logic [Y_WIDTH-1:0] step_pos(input logic [Y_WIDTH-1:0] y,
                                                    input logic go_up,
                                                    input logic [Y_WIDTH-1:0] step);
        logic [Y_WIDTH:0] y_x;
        logic [Y_WIDTH:0] step_x;
        logic [Y_WIDTH:0] sum_x;
        y_x    = {1'b0, y};
        step_x = {1'b0, step};
        sum_x  = y_x + step_x;
        if (go_up) begin
            if (y_x < step_x) return '0;
            return Y_WIDTH'(y_x - step_x);
        end
        if (sum_x > Y_MAX_X) return Y_WIDTH'(Y_MAX_X);
        return Y_WIDTH'(sum_x);
    endfunction

    assign move_tick  = (tick_cnt_q == CNT_LAST);
    assign tick_cnt_d = move_tick ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            y_d[p]      = y_q[p];
            hold_d[p]   = hold_q[p];
            dir_up_d[p] = dir_up_q[p];
            state_d[p]  = state_q[p];
            if (recenter_q) begin
                y_d[p]     = CENTER_Y;
                hold_d[p]  = '0;
                state_d[p] = IDLE;
            end else if (freeze_q) begin
                hold_d[p]  = '0;
                state_d[p] = IDLE;
            end else if (move_tick) begin
                // Both keys on one paddle cancel out and count as no request.
                if (up_q[p] == down_q[p]) begin
                    hold_d[p]  = '0;
                    state_d[p] = IDLE;
                end else if (state_q[p] == IDLE || up_q[p] != dir_up_q[p]) begin
                    y_d[p]      = step_pos(y_q[p], up_q[p], SLOW_Y);
                    dir_up_d[p] = up_q[p];
                    hold_d[p]   = HOLD_W'(1);
                    state_d[p]  = SLOW;
                end else if (state_q[p] == FAST || hold_q[p] == HOLD_MAX) begin
                    y_d[p]     = step_pos(y_q[p], up_q[p], FAST_Y);
                    state_d[p] = FAST;
                end else begin
                    y_d[p]    = step_pos(y_q[p], up_q[p], SLOW_Y);
                    hold_d[p] = hold_q[p] + 1'b1;
                end
            end
            fast_d[p] = (state_d[p] == FAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_q       <= '0;
            down_q     <= '0;
            recenter_q <= 1'b0;
            freeze_q   <= 1'b0;
            tick_cnt_q <= '0;
            y_q        <= {CENTER_Y, CENTER_Y};
            hold_q     <= '0;
            dir_up_q   <= '0;
            fast_q     <= '0;
            state_q[0] <= IDLE;
            state_q[1] <= IDLE;
        end else begin
            up_q       <= {up2, up1};
            down_q     <= {down2, down1};
            recenter_q <= recenter;
            freeze_q   <= freeze;
            tick_cnt_q <= tick_cnt_d;
            y_q        <= y_d;
            hold_q     <= hold_d;
            dir_up_q   <= dir_up_d;
            fast_q     <= fast_d;
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    assign paddle1_y = y_q[0];
    assign paddle2_y = y_q[1];
    assign p1_fast   = fast_q[0];
    assign p2_fast   = fast_q[1];

endmodule

// File: tb/tb_paddle_position_controller.sv
// Scenario bench for paddle_position_controller: a behavioural paddle model pushes expected
// results per move tick into a scoreboard that is drained after the DUT updates.
module tb_paddle_position_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
    logic       recenter = 1'b0, freeze = 1'b0;
    logic [9:0] paddle1_y, paddle2_y;
    logic       p1_fast, p2_fast, move_tick;

    typedef struct {
        int y1;
        int y2;
        bit f1;
        bit f2;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   m_y[2];
    int   m_state[2];
    int   m_hold[2];
    int   m_dir[2];

    paddle_position_controller dut (
        .clk(clk), .rst(rst),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .recenter(recenter), .freeze(freeze),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .p1_fast(p1_fast), .p2_fast(p2_fast), .move_tick(move_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int move(input int y, input int dir, input int step);
        if (dir == 1) return (y < step) ? 0 : y - step;
        return (y + step > 400) ? 400 : y + step;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_y[p] = 200; m_state[p] = 0; m_hold[p] = 0; m_dir[p] = 0;
        end
    endtask

    // Behavioural paddle FSM: state 0 idle, 1 slow, 2 fast; dir 1 up, 2 down.
    task automatic model_tick();
        bit u, d;
        int dir;
        for (int p = 0; p < 2; p++) begin
            u = (p == 0) ? up1 : up2;
            d = (p == 0) ? down1 : down2;
            dir = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
            if (freeze || dir == 0) begin
                m_state[p] = 0; m_hold[p] = 0;
            end else if (m_state[p] == 0 || dir != m_dir[p]) begin
                m_y[p] = move(m_y[p], dir, 4); m_dir[p] = dir; m_hold[p] = 1; m_state[p] = 1;
            end else if (m_state[p] == 2) begin
                m_y[p] = move(m_y[p], dir, 8);
            end else if (m_hold[p] == 8) begin
                m_y[p] = move(m_y[p], dir, 8); m_state[p] = 2;
            end else begin
                m_y[p] = move(m_y[p], dir, 4); m_hold[p]++;
            end
        end
    endtask

    task automatic apply_tick();
        int   waited = 0;
        exp_t e;
        while (move_tick !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (move_tick !== 1'b1) begin
            vectors++; miscompares++;
            $display("[TB] FAIL tick_timeout: move_tick=%b required 1", move_tick);
        end
        model_tick();
        sb_q.push_back('{y1: m_y[0], y2: m_y[1], f1: m_state[0] == 2, f2: m_state[1] == 2});
        @(negedge clk);
        e = sb_q.pop_front();
        vectors += 4;
        if (paddle1_y !== 10'(e.y1)) begin
            miscompares++; $display("[TB] FAIL sb_y1: got %0d required %0d", paddle1_y, e.y1);
        end
        if (paddle2_y !== 10'(e.y2)) begin
            miscompares++; $display("[TB] FAIL sb_y2: got %0d required %0d", paddle2_y, e.y2);
        end
        if (p1_fast !== e.f1) begin
            miscompares++; $display("[TB] FAIL sb_fast1: got %b required %b", p1_fast, e.f1);
        end
        if (p2_fast !== e.f2) begin
            miscompares++; $display("[TB] FAIL sb_fast2: got %b required %b", p2_fast, e.f2);
        end
    endtask

    task automatic pulse_recenter();
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        int gap = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (paddle1_y !== 10'd200 || paddle2_y !== 10'd200 || p1_fast !== 1'b0 ||
            p2_fast !== 1'b0 || move_tick !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: y1=%0d y2=%0d f=%b%b tick=%b required 200 200 00 0",
                     paddle1_y, paddle2_y, p1_fast, p2_fast, move_tick);
        end
        rst = 1'b1;
        model_reset();
        while (move_tick !== 1'b1 && gap < 8) begin @(negedge clk); gap++; end
        vectors++;
        if (gap != 3) begin
            miscompares++; $display("[TB] FAIL first_tick: after %0d cycles required 3", gap);
        end
        gap = 0;
        @(negedge clk);
        gap++;
        while (move_tick !== 1'b1 && gap < 8) begin @(negedge clk); gap++; end
        vectors++;
        if (gap != 4) begin
            miscompares++; $display("[TB] FAIL tick_period: got %0d required 4", gap);
        end
        @(negedge clk);
    endtask

    task automatic test_single_tap();
        up1 = 1'b1;
        apply_tick();
        up1 = 1'b0;
        vectors++;
        if (paddle1_y !== 10'd196 || paddle2_y !== 10'd200) begin
            miscompares++;
            $display("[TB] FAIL single_tap: y1=%0d y2=%0d required 196 200", paddle1_y, paddle2_y);
        end
        apply_tick();
    endtask

    task automatic test_acceleration();
        down2 = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            apply_tick();
            if (t == 8) begin
                vectors++;
                if (paddle2_y !== 10'd232 || p2_fast !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL accel_slow: y2=%0d fast=%b required 232 0", paddle2_y, p2_fast);
                end
            end
            if (t == 9) begin
                vectors++;
                if (p2_fast !== 1'b1) begin
                    miscompares++; $display("[TB] FAIL accel_fast: got %b required 1", p2_fast);
                end
            end
        end
        down2 = 1'b0;
        vectors++;
        if (paddle2_y !== 10'd264) begin
            miscompares++; $display("[TB] FAIL accel_end: got %0d required 264", paddle2_y);
        end
        apply_tick();
    endtask

    task automatic test_top_clamp();
        pulse_recenter();
        up1 = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            apply_tick();
            if (t == 8 && paddle1_y !== 10'd168) begin
                miscompares++; $display("[TB] FAIL top_slow: got %0d required 168", paddle1_y);
            end
            if (t == 28 && paddle1_y === 10'd0) begin
                miscompares++; $display("[TB] FAIL top_early: reached 0 at tick 28");
            end
            if (t >= 29 && paddle1_y !== 10'd0) begin
                miscompares++; $display("[TB] FAIL top_clamp: tick %0d got %0d required 0", t, paddle1_y);
            end
        end
        vectors += 6;
    endtask

    task automatic test_reversal();
        up1 = 1'b0;
        down1 = 1'b1;
        apply_tick();
        vectors++;
        if (paddle1_y !== 10'd4 || p1_fast !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reversal: y1=%0d fast=%b required 4 0", paddle1_y, p1_fast);
        end
        up1 = 1'b1;
        apply_tick();
        vectors++;
        if (paddle1_y !== 10'd4) begin
            miscompares++; $display("[TB] FAIL conflict: got %0d required 4", paddle1_y);
        end
        up1 = 1'b0;
        apply_tick();
        vectors++;
        if (paddle1_y !== 10'd8 || p1_fast !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL restart_slow: y1=%0d fast=%b required 8 0", paddle1_y, p1_fast);
        end
    endtask

    task automatic test_bottom_clamp();
        for (int t = 0; t < 60; t++) apply_tick();
        down1 = 1'b0;
        vectors++;
        if (paddle1_y !== 10'd400) begin
            miscompares++; $display("[TB] FAIL bottom_clamp: got %0d required 400", paddle1_y);
        end
        apply_tick();
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        up2 = 1'b1;
        for (int t = 0; t < 5; t++) apply_tick();
        vectors++;
        if (paddle2_y !== 10'd200) begin
            miscompares++; $display("[TB] FAIL freeze_hold: got %0d required 200", paddle2_y);
        end
        freeze = 1'b0;
        apply_tick();
        vectors++;
        if (paddle2_y !== 10'd196) begin
            miscompares++; $display("[TB] FAIL freeze_release: got %0d required 196", paddle2_y);
        end
        up2 = 1'b0;
        apply_tick();
    endtask

    task automatic test_recenter();
        down1 = 1'b1;
        up2 = 1'b1;
        for (int t = 0; t < 3; t++) apply_tick();
        down1 = 1'b0;
        up2 = 1'b0;
        pulse_recenter();
        vectors++;
        if (paddle1_y !== 10'd200 || paddle2_y !== 10'd200 || move_tick !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL recenter: y1=%0d y2=%0d tick=%b required 200 200 0",
                     paddle1_y, paddle2_y, move_tick);
        end
        apply_tick();
    endtask

    task automatic test_async_reset();
        up1 = 1'b1;
        for (int t = 0; t < 11; t++) apply_tick();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (paddle1_y !== 10'd200 || p1_fast !== 1'b0 || move_tick !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: y1=%0d fast=%b tick=%b required 200 0 0",
                     paddle1_y, p1_fast, move_tick);
        end
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        apply_tick();
        vectors++;
        if (paddle1_y !== 10'd196) begin
            miscompares++; $display("[TB] FAIL reset_resume: got %0d required 196", paddle1_y);
        end
        up1 = 1'b0;
        apply_tick();
    endtask

    initial begin
        $display("[TB] paddle_position_controller bench start");
        model_reset();
        test_reset();
        test_single_tap();
        test_acceleration();
        test_top_clamp();
        test_reversal();
        test_bottom_clamp();
        pulse_recenter();
        test_freeze();
        test_recenter();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/paddle_position_controller.md
Name: paddle_position_controller

Overview:
- Consumes the four keypad direction levels (up1, down1, up2, down2) and maintains the vertical position of both Pong paddles.
- Positions update on an internal move tick and are clamped to the playfield.
- Each paddle has a hold-to-accelerate state machine: slow steps at first, fast steps after a sustained press.
- Outputs feed the ball/collision logic and the VGA renderer directly.

Parameters:
- Y_WIDTH, 10, width of the position outputs.
- SCREEN_H, 480, playfield height in pixels.
- PADDLE_H, 80, paddle height in pixels. Y_MAX = SCREEN_H-PADDLE_H = 400. CENTER = Y_MAX/2 = 200.
- TICK_DIV, 4, clk cycles per move tick (legal range ≥ 2).
- SLOW_STEP, 4, pixels per tick in SLOW state.
- FAST_STEP, 8, pixels per tick in FAST state.
- ACCEL_TICKS, 8, number of consecutive same-direction slow moves before switching to FAST.

Ports:
- clk  in  1  system clock (same clock as the keypad controller).
- rst  in  1  asynchronous, active-low reset.
- up1  in  1  paddle 1 up request, level.
- down1  in  1  paddle 1 down request, level.
- up2  in  1  paddle 2 up request, level.
- down2  in  1  paddle 2 down request, level.
- recenter  in  1  synchronous one-cycle pulse: re-centre both paddles.
- freeze  in  1  level: hold both paddles (pause or serve).
- paddle1_y  out  Y_WIDTH  top edge of paddle 1; 0 = screen top; y grows downward.
- paddle2_y  out  Y_WIDTH  top edge of paddle 2.
- p1_fast  out  1  high while paddle 1 FSM is in FAST.
- p2_fast  out  1  high while paddle 2 FSM is in FAST.
- move_tick  out  1  one-cycle strobe marking the move tick.

Behaviour:
- Reset (rst=0, asynchronous):
  - paddle1_y = paddle2_y = CENTER.
  - Both FSMs go to IDLE and hold counters clear to 0.
  - Tick counter clears to 0.
  - p1_fast = p2_fast = move_tick = 0.
- Input stage:
  - All six control inputs are registered once.
  - The per-paddle direction is UP, DOWN or NONE.
  - up and down both asserted on the same paddle is treated as NONE.
- Tick generation:
  - Counter runs 0..TICK_DIV-1 continuously, including during freeze and recenter.
  - move_tick=1 in the cycle the counter equals TICK_DIV-1.
- Latency: a direction registered in cycle n with move_tick in cycle n changes paddle*_y at the clock edge ending cycle n. Output is registered and visible in cycle n+1.
- Per-paddle FSM (independent copies, evaluated only when move_tick=1):
  - IDLE:
    - UP or DOWN: move SLOW_STEP, store dir, hold=1, go to SLOW.
    - NONE: stay in IDLE.
  - SLOW:
    - Same dir and hold==ACCEL_TICKS: move FAST_STEP, go to FAST.
    - Same dir, otherwise: move SLOW_STEP, hold++.
    - Opposite dir: move SLOW_STEP in the new dir, hold=1, stay in SLOW.
    - NONE: go to IDLE, hold=0, no move.
  - FAST:
    - Same dir: move FAST_STEP.
    - Opposite dir: move SLOW_STEP in the new dir, hold=1, go to SLOW.
    - NONE: go to IDLE, hold=0.
  - p*_fast is asserted exactly while the FSM is in FAST.
- Arithmetic and clamping:
  - Computed in Y_WIDTH+1 bits; no wrap-around.
  - UP: if y < step then y=0, else y-step.
  - DOWN: if y+step > Y_MAX then y=Y_MAX, else y+step.
  - Clamping does not change FSM state.
- Priority, highest first:
  - rst.
  - recenter: both y=CENTER, both FSMs to IDLE with hold=0, regardless of move_tick.
  - freeze: positions hold; FSMs forced to IDLE with hold=0.
  - Normal operation.
- Freeze release: the next tick with a held key starts from IDLE, so the first move is SLOW_STEP.
- Asynchronous reset mid-hold: the paddle returns to CENTER immediately. After release, movement resumes with a SLOW step on the next tick if the key is still held.
- Paddles never interact; simultaneous movement of both paddles is fully supported.

Test Plan:
- Reset: assert rst=0 for 3 cycles, then release -> paddle1_y = paddle2_y = 200, p1_fast = p2_fast = 0, move_tick period 4 clocks.
- Single tap: up1 held for exactly 1 tick -> paddle1_y = 196, FSM back to IDLE on the next tick; paddle2_y stays 200.
- Acceleration: down2 held for 12 ticks -> 8 slow moves give 232; tick 9 sets p2_fast=1; after tick 12 paddle2_y = 264.
- Top clamp: up1 held continuously -> 168 after 8 ticks, then -8 per tick, reaching 0 at tick 29; further ticks hold 0 with no wrap. Bottom clamp mirrors this with down1 and holds 400.
- Reversal and conflict, paddle 1 in FAST:
  - Switch to down1 -> next tick moves +4 and p1_fast drops.
  - Assert up1 and down1 together -> no move, FSM to IDLE.
- Freeze and recenter:
  - freeze=1 while up2 is held for 5 ticks -> paddle2_y unchanged.
  - A recenter pulse at a non-tick cycle -> both y=200 on the next cycle.
  - Async rst pulse mid-move -> immediate 200, with no clk edge needed.
